// File: rtl/nibble_packer.sv
// Packs pairs of 4-bit nibbles into bytes behind a valid/ready output register.
// A flush request emits a lone held nibble as a zero-padded partial byte.
module nibble_packer #(
    parameter bit LSN_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data,
    input  logic        en,
    output logic        in_ready,
    input  logic        flush,
    output logic        flush_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_partial,
    output logic [15:0] byte_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] hold;

    logic       out_free;
    logic       in_hs;
    logic       out_hs;
    logic       flush_service;
    logic       load_full;
    logic       load_partial;
    logic [7:0] full_byte;
    logic [7:0] partial_byte;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_next = HALF;
                end
            end
            HALF: begin
                if (in_hs || flush_service) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake and load strobes; the output slot is free when empty or draining this cycle
    always_comb begin
        out_free      = !out_valid || out_ready;
        in_ready      = (state == EMPTY) || out_free;
        in_hs         = en && in_ready;
        out_hs        = out_valid && out_ready;
        flush_service = flush && !flush_done && !in_hs &&
                        ((state == EMPTY) || out_free);
        load_full     = in_hs && (state == HALF);
        load_partial  = flush_service && (state == HALF);
    end

    always_comb begin
        if (LSN_FIRST) begin
            full_byte    = {data, hold};
            partial_byte = {4'h0, hold};
        end else begin
            full_byte    = {hold, data};
            partial_byte = {hold, 4'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= 4'h0;
        end else if (in_hs && (state == EMPTY)) begin
            hold <= data;
        end
    end

    // A new load takes priority over clearing, so a drained byte is replaced without a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
        end else if (load_full) begin
            out_data    <= full_byte;
            out_valid   <= 1'b1;
            out_partial <= 1'b0;
        end else if (load_partial) begin
            out_data    <= partial_byte;
            out_valid   <= 1'b1;
            out_partial <= 1'b1;
        end else if (out_hs) begin
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_done <= 1'b0;
        end else begin
            flush_done <= flush_service;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count <= 16'h0000;
        end else if (out_hs) begin
            byte_count <= byte_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: one instance per nibble order, shared stimulus.
module tb_nibble_packer;

    logic        clk;
    logic        rst;
    logic [3:0]  data;
    logic        en;
    logic        flush;
    logic        out_ready;

    logic        l_in_ready, l_flush_done, l_out_valid, l_out_partial;
    logic [7:0]  l_out_data;
    logic [15:0] l_byte_count;
    logic        m_in_ready, m_flush_done, m_out_valid, m_out_partial;
    logic [7:0]  m_out_data;
    logic [15:0] m_byte_count;

    int checks;
    int errors;

    nibble_packer #(.LSN_FIRST(1'b1)) u_lsn (
        .clk(clk), .rst(rst), .data(data), .en(en), .in_ready(l_in_ready),
        .flush(flush), .flush_done(l_flush_done), .out_data(l_out_data),
        .out_valid(l_out_valid), .out_ready(out_ready),
        .out_partial(l_out_partial), .byte_count(l_byte_count)
    );

    nibble_packer #(.LSN_FIRST(1'b0)) u_msn (
        .clk(clk), .rst(rst), .data(data), .en(en), .in_ready(m_in_ready),
        .flush(flush), .flush_done(m_flush_done), .out_data(m_out_data),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .out_partial(m_out_partial), .byte_count(m_byte_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; data = 4'h0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {15'd0, l_out_valid}, 16'h0);
        check("rst_out_data", {8'd0, l_out_data}, 16'h00);
        check("rst_out_partial", {15'd0, l_out_partial}, 16'h0);
        check("rst_flush_done", {15'd0, l_flush_done}, 16'h0);
        check("rst_byte_count", l_byte_count, 16'h0000);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", {15'd0, l_in_ready}, 16'h1);

        // 0x5 then 0xA with free output
        en = 1'b1; data = 4'h5;
        tick();
        check("half_no_output", {15'd0, l_out_valid}, 16'h0);
        data = 4'hA;
        tick();
        en = 1'b0;
        check("lsn_valid", {15'd0, l_out_valid}, 16'h1);
        check("lsn_byte", {8'd0, l_out_data}, 16'h00A5);
        check("lsn_partial", {15'd0, l_out_partial}, 16'h0);
        check("msn_byte", {8'd0, m_out_data}, 16'h005A);
        tick();
        check("drain_valid", {15'd0, l_out_valid}, 16'h0);
        check("count_one", l_byte_count, 16'h0001);
        check("msn_count_one", m_byte_count, 16'h0001);

        // Backpressure: 0x21 stalls, 0x3 held, then 0x21/0x43 back-to-back
        out_ready = 1'b0;
        en = 1'b1; data = 4'h1;
        tick();
        data = 4'h2;
        tick();
        check("stall_byte", {8'd0, l_out_data}, 16'h0021);
        data = 4'h3;
        tick();
        check("stall_in_ready", {15'd0, l_in_ready}, 16'h0);
        data = 4'h4;
        tick();
        check("stall_hold_byte", {8'd0, l_out_data}, 16'h0021);
        check("stall_hold_valid", {15'd0, l_out_valid}, 16'h1);
        check("stall_count", l_byte_count, 16'h0001);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {15'd0, l_in_ready}, 16'h1);
        tick();
        en = 1'b0;
        check("b2b_byte", {8'd0, l_out_data}, 16'h0043);
        check("b2b_valid", {15'd0, l_out_valid}, 16'h1);
        check("b2b_count", l_byte_count, 16'h0002);
        check("b2b_msn_byte", {8'd0, m_out_data}, 16'h0034);
        tick();
        check("b2b_drain_valid", {15'd0, l_out_valid}, 16'h0);
        check("b2b_drain_count", l_byte_count, 16'h0003);

        // Flush with 0x7 held, then flush while empty
        en = 1'b1; data = 4'h7;
        tick();
        en = 1'b0; flush = 1'b1;
        tick();
        check("flush_byte", {8'd0, l_out_data}, 16'h0007);
        check("flush_partial", {15'd0, l_out_partial}, 16'h1);
        check("flush_valid", {15'd0, l_out_valid}, 16'h1);
        check("flush_done", {15'd0, l_flush_done}, 16'h1);
        check("flush_msn_byte", {8'd0, m_out_data}, 16'h0070);
        flush = 1'b0;
        tick();
        check("flush_done_drop", {15'd0, l_flush_done}, 16'h0);
        check("flush_partial_clr", {15'd0, l_out_partial}, 16'h0);
        check("flush_count", l_byte_count, 16'h0004);
        flush = 1'b1;
        tick();
        check("empty_flush_done", {15'd0, l_flush_done}, 16'h1);
        check("empty_flush_no_byte", {15'd0, l_out_valid}, 16'h0);
        flush = 1'b0;
        tick();
        check("empty_flush_drop", {15'd0, l_flush_done}, 16'h0);
        check("empty_flush_count", l_byte_count, 16'h0004);

        // Reset while holding 0x9 discards it
        en = 1'b1; data = 4'h9;
        tick();
        en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {15'd0, l_out_valid}, 16'h0);
        check("midrst_count", l_byte_count, 16'h0000);
        check("midrst_in_ready", {15'd0, l_in_ready}, 16'h1);
        en = 1'b1; data = 4'h1;
        tick();
        data = 4'h2;
        tick();
        en = 1'b0;
        check("midrst_byte", {8'd0, l_out_data}, 16'h0021);
        check("midrst_partial", {15'd0, l_out_partial}, 16'h0);
        tick();
        check("midrst_count_one", l_byte_count, 16'h0001);

        // Counter wrap: preset to 0xFFFF, then one more handshake
        force u_lsn.byte_count = 16'hFFFF;
        tick();
        release u_lsn.byte_count;
        #1;
        check("wrap_preset", l_byte_count, 16'hFFFF);
        en = 1'b1; data = 4'hC;
        tick();
        data = 4'h3;
        tick();
        en = 1'b0;
        check("wrap_byte", {8'd0, l_out_data}, 16'h003C);
        check("wrap_before", l_byte_count, 16'hFFFF);
        tick();
        check("wrap_count", l_byte_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
